// File: rtl/tlul_host_adapter_ordered.sv
// TL-UL host adapter: up to MAX_REQS outstanding transactions, responses delivered in issue order.
// Optional TLUL_HOST_ADAPTER_SUBWORD_EN: naturally aligned byte/half-word accesses use a_size 0/1.

package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

module tlul_host_adapter_ordered
  import tlul_pkg::*;
#(
  parameter int MAX_REQS = 4,
  parameter int PTR_W    = (MAX_REQS > 1) ? $clog2(MAX_REQS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [TL_AW-1:0]  addr_i,
  input  logic              we_i,
  input  logic [TL_DW-1:0]  wdata_i,
  input  logic [TL_DBW-1:0] be_i,
  output logic              valid_o,
  output logic [TL_DW-1:0]  rdata_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              unexp_rsp_o,
  output tl_h2d_t           tl_h_c_a,
  input  tl_d2h_t           tl_h_c_d
);

  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(TL_DBW);

  logic [MAX_REQS-1:0] pend;
  logic [MAX_REQS-1:0] done;
  logic [MAX_REQS-1:0] we_mem;
  logic [MAX_REQS-1:0] err_mem;
  logic [TL_DW-1:0]    rdata_mem [MAX_REQS];

  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;
  logic [CNT_W-1:0]  cnt;

  logic              full;
  logic              a_valid;
  logic [31:0]       d_src_ext;
  logic              src_ok;
  logic [PTR_W-1:0]  d_idx;
  logic              d_hit;
  logic              d_miss;
  logic [TL_DW-1:0]  d_store_data;
  logic              bypass;
  logic              retire;
  logic [TL_DW-1:0]  ret_data;
  logic              ret_err;

  logic [TL_SZW-1:0] a_size;
  logic [OFF_W-1:0]  a_off;
  logic [TL_DBW-1:0] rd_mask;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_REQS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CNT_W'(MAX_REQS));
  assign a_valid = req_i & ~full;
  assign gnt_o   = a_valid & tl_h_c_d.a_ready;
  assign busy_o  = (cnt != '0);

  // Sources at or above MAX_REQS can never be outstanding; gate the slot lookup with src_ok.
  assign d_src_ext    = 32'(tl_h_c_d.d_source);
  assign src_ok       = (d_src_ext < 32'(MAX_REQS));
  assign d_idx        = tl_h_c_d.d_source[PTR_W-1:0];
  assign d_hit        = tl_h_c_d.d_valid & src_ok & pend[d_idx];
  assign d_miss       = tl_h_c_d.d_valid & ~d_hit;
  assign d_store_data = we_mem[d_idx] ? '0 : tl_h_c_d.d_data;

  // A response for the oldest slot retires straight from the D beat, giving 1-cycle latency.
  assign bypass   = d_hit & (d_idx == rp);
  assign retire   = done[rp] | bypass;
  assign ret_data = done[rp] ? rdata_mem[rp] : d_store_data;
  assign ret_err  = done[rp] ? err_mem[rp]   : tl_h_c_d.d_error;

  always_comb begin
    a_size  = TL_SZW'(OFF_W);
    a_off   = '0;
    rd_mask = '1;
`ifdef TLUL_HOST_ADAPTER_SUBWORD_EN
    case (be_i)
      4'b0001: begin a_size = 2'd0; a_off = OFF_W'(0); rd_mask = be_i; end
      4'b0010: begin a_size = 2'd0; a_off = OFF_W'(1); rd_mask = be_i; end
      4'b0100: begin a_size = 2'd0; a_off = OFF_W'(2); rd_mask = be_i; end
      4'b1000: begin a_size = 2'd0; a_off = OFF_W'(3); rd_mask = be_i; end
      4'b0011: begin a_size = 2'd1; a_off = OFF_W'(0); rd_mask = be_i; end
      4'b1100: begin a_size = 2'd1; a_off = OFF_W'(2); rd_mask = be_i; end
      default: ;
    endcase
`endif
  end

  always_comb begin
    tl_h_c_a           = '0;
    tl_h_c_a.a_valid   = a_valid;
    tl_h_c_a.a_opcode  = ~we_i ? Get : (&be_i ? PutFullData : PutPartialData);
    tl_h_c_a.a_param   = 3'd0;
    tl_h_c_a.a_size    = a_size;
    tl_h_c_a.a_source  = TL_AIW'(wp);
    tl_h_c_a.a_address = {addr_i[TL_AW-1:OFF_W], a_off};
    tl_h_c_a.a_mask    = we_i ? be_i : rd_mask;
    tl_h_c_a.a_data    = wdata_i;
    tl_h_c_a.d_ready   = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend        <= '0;
      done        <= '0;
      we_mem      <= '0;
      err_mem     <= '0;
      wp          <= '0;
      rp          <= '0;
      cnt         <= '0;
      valid_o     <= 1'b0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      unexp_rsp_o <= 1'b0;
    end else begin
      valid_o     <= retire;
      unexp_rsp_o <= d_miss;
      if (retire) begin
        rdata_o  <= ret_data;
        err_o    <= ret_err;
        done[rp] <= 1'b0;
        rp       <= ptr_inc(rp);
      end
      if (d_hit) begin
        pend[d_idx] <= 1'b0;
        if (!bypass) begin
          done[d_idx]    <= 1'b1;
          err_mem[d_idx] <= tl_h_c_d.d_error;
        end
      end
      // The granted slot is free (cnt < MAX_REQS), so it never collides with d_idx or rp.
      if (gnt_o) begin
        pend[wp]   <= 1'b1;
        we_mem[wp] <= we_i;
        wp         <= ptr_inc(wp);
      end
      case ({gnt_o, retire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (d_hit && !bypass) rdata_mem[d_idx] <= d_store_data;
  end

  logic unused_sig;
  assign unused_sig = ^{tl_h_c_d.d_opcode, tl_h_c_d.d_param, tl_h_c_d.d_size,
                        tl_h_c_d.d_sink, addr_i[OFF_W-1:0]};

endmodule
